// File: rtl/load_store_unit_if.sv
// load_store_unit_if: valid/ready data-memory request port with load-response return.
interface load_store_unit_if #(parameter int XLEN = 64);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_write;
  logic [XLEN-1:0] mem_req_wdata;
  logic [XLEN/8-1:0] mem_req_wstrb;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;
  modport master (
    output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage; issues valid/ready data-memory requests,
// formats stores, extends loads and stalls the pipeline while an access is outstanding.
module load_store_unit #(
  parameter int XLEN   = 64,
  parameter int FUNCT3 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_read_enable,
  input  logic              ex_write_enable,
  input  logic [FUNCT3-1:0] ex_funct3,
  input  logic [XLEN-1:0]   ex_address,
  input  logic [XLEN-1:0]   ex_write_data,
  load_store_unit_if.master mem,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic [XLEN-1:0]   dm_read_data,
  output logic [XLEN-1:0]   dm_data_bypass,
  output logic              mem_exception
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT_RSP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d, byp_q, byp_d;
  logic [FUNCT3-1:0] f3_q, f3_d;
  logic [XLEN/8-1:0] wstrb_q, wstrb_d;
  logic write_q, write_d, wb_q, wb_d, exc_q, exc_d;
  logic mem_op, illegal, misaligned;
  logic [2:0] lane;
  logic [XLEN-1:0] shifted, ext, fmt_wdata;
  logic [XLEN/8-1:0] fmt_wstrb;
  assign mem_op = ex_read_enable | ex_write_enable;
  assign illegal = (ex_read_enable & ex_write_enable) | (ex_write_enable & ex_funct3[2]) |
                   (ex_read_enable & (ex_funct3 == 3'b111));
  assign misaligned = ((ex_funct3[1:0] == 2'b01) & ex_address[0]) |
                      ((ex_funct3[1:0] == 2'b10) & (|ex_address[1:0])) |
                      ((ex_funct3[1:0] == 2'b11) & (|ex_address[2:0]));
  assign lane = ex_address[2:0];
  assign fmt_wstrb = ex_funct3[1:0] == 2'b00 ? 8'h01 << lane :
                     ex_funct3[1:0] == 2'b01 ? 8'h03 << lane :
                     ex_funct3[1:0] == 2'b10 ? 8'h0F << lane : 8'hFF;
  assign fmt_wdata = ex_funct3[1:0] == 2'b00 ? {8{ex_write_data[7:0]}} :
                     ex_funct3[1:0] == 2'b01 ? {4{ex_write_data[15:0]}} :
                     ex_funct3[1:0] == 2'b10 ? {2{ex_write_data[31:0]}} : ex_write_data;
  // Response arrives as the aligned doubleword; bring the addressed lane down to bit 0.
  assign shifted = mem.mem_rsp_rdata >> {addr_q[2:0], 3'b000};
  assign ext = f3_q == 3'b000 ? {{(XLEN-8){shifted[7]}}, shifted[7:0]} :
               f3_q == 3'b001 ? {{(XLEN-16){shifted[15]}}, shifted[15:0]} :
               f3_q == 3'b010 ? {{(XLEN-32){shifted[31]}}, shifted[31:0]} :
               f3_q == 3'b100 ? {{(XLEN-8){1'b0}}, shifted[7:0]} :
               f3_q == 3'b101 ? {{(XLEN-16){1'b0}}, shifted[15:0]} :
               f3_q == 3'b110 ? {{(XLEN-32){1'b0}}, shifted[31:0]} : shifted;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    f3_d = f3_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rd_d = rd_q;
    byp_d = byp_q;
    wb_d = 1'b0;
    exc_d = 1'b0;
    mem_stall = 1'b0;
    if (state_q == IDLE && ex_valid) begin
      if (!mem_op) begin
        byp_d = ex_address;
        wb_d = 1'b1;
      end else if (illegal | misaligned) begin
        wb_d = 1'b1;
        exc_d = 1'b1;
      end else begin
        state_d = REQ;
        addr_d = ex_address;
        f3_d = ex_funct3;
        write_d = ex_write_enable;
        wdata_d = ex_write_enable ? fmt_wdata : '0;
        wstrb_d = ex_write_enable ? fmt_wstrb : '0;
        mem_stall = 1'b1;
      end
    end else if (state_q == REQ) begin
      mem_stall = !(mem.mem_req_ready & write_q);
      if (mem.mem_req_ready) begin
        state_d = write_q ? IDLE : WAIT_RSP;
        wb_d = write_q;
      end
    end else if (state_q == WAIT_RSP) begin
      mem_stall = !mem.mem_rsp_valid;
      if (mem.mem_rsp_valid) begin
        rd_d = ext;
        wb_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      f3_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rd_q <= '0;
      byp_q <= '0;
      wb_q <= 1'b0;
      exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      f3_q <= f3_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rd_q <= rd_d;
      byp_q <= byp_d;
      wb_q <= wb_d;
      exc_q <= exc_d;
    end
  end
  assign mem.mem_req_valid = state_q == REQ;
  assign mem.mem_req_addr = {addr_q[XLEN-1:3], 3'b000};
  assign mem.mem_req_write = write_q;
  assign mem.mem_req_wdata = wdata_q;
  assign mem.mem_req_wstrb = wstrb_q;
  assign wb_valid = wb_q;
  assign mem_exception = exc_q;
  assign dm_read_data = rd_q;
  assign dm_data_bypass = byp_q;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage responder for the 5-stage pipeline.
- Consumes execute-stage load/store requests: ALU address, store data, funct3, read/write enables.
- Drives a valid/ready data-memory port, aligns and extends load data, and produces dm_read_data and dm_data_bypass for the pipeline forwarding logic.
- Stalls the pipeline while a variable-latency memory access is outstanding.

Parameters:
XLEN, 64, data/address width; strobe width is XLEN/8 (only 64 supported)
FUNCT3, 3, width of the access-size field

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
ex_valid  in  1  execute stage presents an instruction this cycle
ex_read_enable  in  1  instruction is a load
ex_write_enable  in  1  instruction is a store
ex_funct3  in  FUNCT3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
ex_address  in  XLEN  ALU result: effective address, or ALU data for non-memory ops
ex_write_data  in  XLEN  store data, right-aligned
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  ex_address with bits [2:0] cleared
mem_req_write  out  1  1 = store
mem_req_wdata  out  XLEN  lane-replicated store data
mem_req_wstrb  out  XLEN/8  byte enables (stores only; 0 for loads)
mem_rsp_valid  in  1  load data returned
mem_rsp_rdata  in  XLEN  aligned 8-byte load data
mem_stall  out  1  combinational; upstream holds ex_* stable while high
wb_valid  out  1  one-cycle pulse: instruction retired from this stage
dm_read_data  out  XLEN  extended load result
dm_data_bypass  out  XLEN  registered ex_address of a non-memory instruction
mem_exception  out  1  one-cycle pulse: misaligned or illegal access

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0: mem_req_valid, wb_valid, mem_exception, mem_req_* and dm_* registers.
  - Reset mid-transaction drops mem_req_valid immediately. A later mem_rsp_valid is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE, ex_valid=1, neither enable set:
  - dm_data_bypass <= ex_address.
  - wb_valid=1 next cycle, mem_stall=0. Latency 1.
- IDLE, ex_valid=1, memory op: check legality.
  - Illegal if read and write are both set.
  - Illegal if a store has funct3[2]=1, or a load has funct3=111.
  - Misaligned if H/HU addr[0]≠0, W/WU addr[1:0]≠0, or D addr[2:0]≠0.
  - Illegal or misaligned: no request is issued; mem_exception=1 and wb_valid=1 next cycle; dm_read_data unchanged; mem_stall=0.
  - Legal: capture address, funct3, direction, wdata and wstrb; go to REQ; mem_stall=1 in this cycle.
- REQ:
  - mem_req_valid=1; all mem_req_* stay stable until mem_req_ready.
  - On ready with a store: go to IDLE, mem_stall=0 this cycle, wb_valid next cycle.
  - On ready with a load: go to WAIT_RSP, mem_stall=1.
- WAIT_RSP:
  - mem_stall = !mem_rsp_valid.
  - On mem_rsp_valid: dm_read_data <= extended lane, wb_valid next cycle, go to IDLE.
- mem_rsp_valid outside WAIT_RSP is ignored.
- ex_* are ignored while the FSM is not in IDLE. The held instruction advances on the edge where mem_stall=0.
- Minimum latency with zero-wait memory:
  - Load: 3 cycles, request cycle to wb_valid.
  - Store: 2 cycles.
- Load extraction:
  - lane = addr[2:0]; shifted = rdata >> (8*lane).
  - B/H/W sign-extend bit 7/15/31; BU/HU/WU zero-extend; D passes through.
- Store formatting:
  - wstrb: SB 0x01<<lane, SH 0x03<<lane, SW 0x0F<<lane, SD 0xFF.
  - wdata: byte replicated 8x, half replicated 4x, word replicated 2x, double as-is.
- wb_valid and mem_exception never assert in the same cycle as mem_stall for the same instruction.
- x0 handling and forwarding select are not this block's concern.

Test Plan:
- Reset/bypass: rst low mid-REQ → mem_req_valid drops the same cycle. After release, ex_valid with no enables and ex_address=0x1234 → dm_data_bypass=0x1234 and wb_valid=1 one cycle later, mem_stall=0.
- LB sign: addr 0x1003, rdata 0x00000000_80FF7F00, zero-wait → dm_read_data=0xFFFFFFFF_FFFFFF80 on the 3rd cycle; same access as LBU → 0x80.
- LW with wait states: addr 0x2004, ready delayed 2 cycles, rsp delayed 3 cycles, rdata 0x87654321_00000000 → mem_req_* stable while waiting; mem_stall held; dm_read_data=0xFFFFFFFF_87654321.
- SH: addr 0x3006, data 0xABCD → mem_req_addr=0x3000, wstrb=0xC0, wdata=0xABCDABCD_ABCDABCD, wb_valid the cycle after ready.
- Misaligned LD at 0x4004 and SW with read and write both set → mem_exception pulses, no mem_req_valid, mem_stall=0.
- Spurious mem_rsp_valid in IDLE and REQ → no wb_valid, dm_read_data unchanged.
